prio_enc_8to3: RTL and testbench

- Sequential 8-to-3 priority encoder. It is the reverse direction of the team's 3-to-8 active-low line decoder.
- Eight active-low request lines, with the same polarity as the decoder's outputs, are synchronised and falling-edge captured into a pending bitmap.
- The highest-priority pending line is offered as a 3-bit code over a valid/ready handshake.
- Typical use: an interrupt/keypad request encoder feeding a controller that drives the 3-to-8 decoder back.

---
 rtl/prio_enc_8to3.sv | 138 +++++++++++++
 tb/tb_prio_enc_8to3.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_8to3.sv
// rtl/prio_enc_8to3.sv - sequential 8-to-3 priority encoder with edge capture and valid/ready offer
module prio_enc_8to3 #(
   parameter int SYNC_STAGES   = 2,
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] req_n_i,
   input  logic       en_n_i,
   input  logic       clr_i,
   output logic [2:0] code_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [7:0] pending_o,
   output logic       overflow_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] hist_q;
   logic [7:0] synced;
   logic [7:0] fall;
   logic [7:0] capture;
   logic [7:0] accept_mask;
   logic [7:0] lost;
   logic [7:0] pending_q;
   logic       overflow_q;
   logic [2:0] code_q;
   logic       valid_q;
   logic       handshake;
   logic [2:0] offer_code;
   state_t     state_q;

   // Request lines cross into the clock domain through a plain flop chain; idle level is 1.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= 8'hFF;
         end
      end else begin
         sync_q[0] <= req_n_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // History of the synchronised level, used to spot a 1 -> 0 transition.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hist_q <= 8'hFF;
      end else begin
         hist_q <= synced;
      end
   end

   // Falling-edge detect, enable gating, and the pending bit being retired by a handshake.
   always_comb begin
      synced      = sync_q[SYNC_STAGES-1];
      fall        = hist_q & ~synced;
      capture     = en_n_i ? 8'h00 : fall;
      handshake   = valid_q & ready_i;
      accept_mask = handshake ? (8'b0000_0001 << code_q) : 8'h00;
      lost        = capture & pending_q & ~accept_mask;
   end

   // Pick the highest-priority pending line; later loop iterations override earlier ones.
   always_comb begin
      offer_code = 3'd0;
      if (PRIORITY_HIGH) begin
         for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) offer_code = 3'(i);
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) offer_code = 3'(i);
         end
      end
   end

   // Pending bitmap and sticky overflow; a new capture wins over the same bit's handshake clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else if (clr_i) begin
         pending_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         pending_q <= (pending_q & ~accept_mask) | capture;
         if (|lost) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Offer FSM: latch a code from the bitmap, hold it until the consumer takes it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         code_q  <= 3'd0;
         valid_q <= 1'b0;
      end else if (clr_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pending_q != 8'h00) begin
                  code_q  <= offer_code;
                  valid_q <= 1'b1;
                  state_q <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (handshake) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign code_o     = code_q;
   assign valid_o    = valid_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_prio_enc_8to3.sv
// tb/tb_prio_enc_8to3.sv - directed bench for prio_enc_8to3 in both priority orders
module tb_prio_enc_8to3;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_n;
   logic       en_n;
   logic       clr;
   logic       ready;
   logic [2:0] code_hi, code_lo;
   logic       valid_hi, valid_lo;
   logic [7:0] pending_hi, pending_lo;
   logic       ovf_hi, ovf_lo;

   int passed = 0;
   int total  = 0;

   prio_enc_8to3 #(.SYNC_STAGES(2), .PRIORITY_HIGH(1'b1)) dut_hi (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .req_n_i    (req_n),
      .en_n_i     (en_n),
      .clr_i      (clr),
      .code_o     (code_hi),
      .valid_o    (valid_hi),
      .ready_i    (ready),
      .pending_o  (pending_hi),
      .overflow_o (ovf_hi)
   );

   prio_enc_8to3 #(.SYNC_STAGES(2), .PRIORITY_HIGH(1'b0)) dut_lo (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .req_n_i    (req_n),
      .en_n_i     (en_n),
      .clr_i      (clr),
      .code_o     (code_lo),
      .valid_o    (valid_lo),
      .ready_i    (ready),
      .pending_o  (pending_lo),
      .overflow_o (ovf_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      req_n = 8'hFF;
      en_n  = 1'b0;
      clr   = 1'b0;
      ready = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset;
      do_reset();
      total++;
      if ({valid_hi, code_hi, pending_hi, ovf_hi} !== 13'h0)
         $display("FAIL reset_state: got v=%b c=%0d p=%h o=%b want all zero", valid_hi, code_hi, pending_hi, ovf_hi);
      else passed++;
      // build an offer on line 2 and leave it unaccepted
      req_n = 8'hFB;
      tick(4);
      req_n = 8'hFF;
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd2)
         $display("FAIL reset_pre_offer: got v=%b c=%0d want v=1 c=2", valid_hi, code_hi);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_hi, code_hi, pending_hi, ovf_hi} !== 13'h0)
         $display("FAIL reset_async: got v=%b c=%0d p=%h o=%b want all zero", valid_hi, code_hi, pending_hi, ovf_hi);
      else passed++;
      tick(1);
      rst_n = 1'b1;
      tick(6);
      total++;
      if (valid_hi !== 1'b0 || pending_hi !== 8'h00)
         $display("FAIL reset_no_replay: got v=%b p=%h want v=0 p=00", valid_hi, pending_hi);
      else passed++;
   endtask

   task automatic test_single;
      do_reset();
      ready = 1'b1;
      req_n = 8'hFB;
      tick(2);
      total++;
      if (pending_hi !== 8'h00)
         $display("FAIL single_early: got pending=%h want 00", pending_hi);
      else passed++;
      tick(1);
      total++;
      if (pending_hi !== 8'h04 || valid_hi !== 1'b0)
         $display("FAIL single_pending: got p=%h v=%b want p=04 v=0", pending_hi, valid_hi);
      else passed++;
      tick(1);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd2)
         $display("FAIL single_offer: got v=%b c=%0d want v=1 c=2", valid_hi, code_hi);
      else passed++;
      tick(1);
      total++;
      if (valid_hi !== 1'b0 || pending_hi !== 8'h00)
         $display("FAIL single_accept: got v=%b p=%h want v=0 p=00", valid_hi, pending_hi);
      else passed++;
      req_n = 8'hFF;
      tick(3);
   endtask

   task automatic test_multi;
      bit         exp_v  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] exp_hi [6] = '{3'd6, 3'd6, 3'd5, 3'd5, 3'd1, 3'd1};
      logic [2:0] exp_lo [6] = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd6, 3'd6};
      do_reset();
      ready = 1'b1;
      req_n = 8'h9D;
      tick(3);
      total++;
      if (pending_hi !== 8'h62 || pending_lo !== 8'h62)
         $display("FAIL multi_pending: got hi=%h lo=%h want 62", pending_hi, pending_lo);
      else passed++;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         total++;
         if (valid_hi !== exp_v[c] || (exp_v[c] && code_hi !== exp_hi[c]))
            $display("FAIL multi_hi_cycle%0d: got v=%b c=%0d want v=%b c=%0d", c, valid_hi, code_hi, exp_v[c], exp_hi[c]);
         else passed++;
         total++;
         if (valid_lo !== exp_v[c] || (exp_v[c] && code_lo !== exp_lo[c]))
            $display("FAIL multi_lo_cycle%0d: got v=%b c=%0d want v=%b c=%0d", c, valid_lo, code_lo, exp_v[c], exp_lo[c]);
         else passed++;
      end
      total++;
      if (pending_hi !== 8'h00 || pending_lo !== 8'h00 || ovf_hi !== 1'b0)
         $display("FAIL multi_drained: got hi=%h lo=%h o=%b want 00 00 0", pending_hi, pending_lo, ovf_hi);
      else passed++;
   endtask

   task automatic test_backpressure;
      do_reset();
      req_n = 8'hDF;
      tick(4);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd5)
         $display("FAIL bp_first: got v=%b c=%0d want v=1 c=5", valid_hi, code_hi);
      else passed++;
      req_n = 8'h5F;
      tick(4);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd5 || pending_hi !== 8'hA0)
         $display("FAIL bp_hold: got v=%b c=%0d p=%h want v=1 c=5 p=a0", valid_hi, code_hi, pending_hi);
      else passed++;
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      total++;
      if (valid_hi !== 1'b0 || pending_hi !== 8'h80)
         $display("FAIL bp_accept: got v=%b p=%h want v=0 p=80", valid_hi, pending_hi);
      else passed++;
      tick(1);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd7)
         $display("FAIL bp_next: got v=%b c=%0d want v=1 c=7", valid_hi, code_hi);
      else passed++;
   endtask

   task automatic test_overflow_clear;
      do_reset();
      req_n = 8'hF7;
      tick(4);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd3 || pending_hi !== 8'h08)
         $display("FAIL ovf_offer: got v=%b c=%0d p=%h want v=1 c=3 p=08", valid_hi, code_hi, pending_hi);
      else passed++;
      req_n = 8'hFF;
      tick(3);
      req_n = 8'hF7;
      tick(3);
      total++;
      if (ovf_hi !== 1'b1 || pending_hi !== 8'h08)
         $display("FAIL ovf_set: got o=%b p=%h want o=1 p=08", ovf_hi, pending_hi);
      else passed++;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      total++;
      if (pending_hi !== 8'h00 || ovf_hi !== 1'b0 || valid_hi !== 1'b0)
         $display("FAIL clr_effect: got p=%h o=%b v=%b want 00 0 0", pending_hi, ovf_hi, valid_hi);
      else passed++;
      tick(2);
      total++;
      if (valid_hi !== 1'b0 || pending_hi !== 8'h00)
         $display("FAIL clr_stays: got v=%b p=%h want v=0 p=00", valid_hi, pending_hi);
      else passed++;
   endtask

   task automatic test_same_cycle_set_clear;
      do_reset();
      req_n = 8'hF7;
      tick(4);
      req_n = 8'hFF;
      tick(3);
      req_n = 8'hF7;
      tick(2);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      total++;
      if (pending_hi !== 8'h08 || ovf_hi !== 1'b0 || valid_hi !== 1'b0)
         $display("FAIL setclr_win: got p=%h o=%b v=%b want p=08 o=0 v=0", pending_hi, ovf_hi, valid_hi);
      else passed++;
      tick(1);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd3)
         $display("FAIL setclr_reoffer: got v=%b c=%0d want v=1 c=3", valid_hi, code_hi);
      else passed++;
   endtask

   task automatic test_enable;
      do_reset();
      en_n  = 1'b1;
      req_n = 8'hFE;
      tick(4);
      total++;
      if (pending_hi !== 8'h00 || valid_hi !== 1'b0)
         $display("FAIL en_gated: got p=%h v=%b want p=00 v=0", pending_hi, valid_hi);
      else passed++;
      en_n = 1'b0;
      tick(4);
      total++;
      if (pending_hi !== 8'h00 || valid_hi !== 1'b0)
         $display("FAIL en_level: got p=%h v=%b want p=00 v=0", pending_hi, valid_hi);
      else passed++;
      req_n = 8'hFF;
      tick(3);
      req_n = 8'hFE;
      tick(4);
      total++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd0 || pending_hi !== 8'h01)
         $display("FAIL en_reedge_hi: got v=%b c=%0d p=%h want v=1 c=0 p=01", valid_hi, code_hi, pending_hi);
      else passed++;
      total++;
      if (valid_lo !== 1'b1 || code_lo !== 3'd0)
         $display("FAIL en_reedge_lo: got v=%b c=%0d want v=1 c=0", valid_lo, code_lo);
      else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      req_n = 8'hFF;
      en_n  = 1'b0;
      clr   = 1'b0;
      ready = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_overflow_clear();
      test_same_cycle_set_clear();
      test_enable();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
